// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock (optional SEQ_DIVIDER_MONITOR_EN prints each result)
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = DIVIDEND_W > 1 ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  part_q, part_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  assign shifted     = {part_q, dvd_q[DIVIDEND_W-1]};
  assign ge          = shifted >= {1'b0, dsr_q};
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  // state, datapath and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end
  // dvd_q doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    part_d  = part_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d   = dividend;
        dsr_d   = divisor;
        part_d  = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        dbz_d   = 1'b0;
        state_d = divisor == '0 ? FIN : RUN;
      end
      RUN: begin
        part_d  = DIVISOR_W'(ge ? shifted - {1'b0, dsr_q} : shifted);
        dvd_d   = {dvd_q[DIVIDEND_W-2:0], ge};
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == LAST ? FIN : RUN;
      end
      FIN: begin
        quot_d  = dsr_q == '0 ? '1 : dvd_q;
        rem_d   = dsr_q == '0 ? dvd_q[DIVISOR_W-1:0] : part_q;
        dbz_d   = dsr_q == '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef SEQ_DIVIDER_MONITOR_EN
  logic [DIVIDEND_W-1:0] mon_dvd_q;
  // dvd_q is consumed by the shift, so keep the original dividend for the report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_dvd_q <= '0;
    else if (state_q == IDLE && start) mon_dvd_q <= dividend;
  end
  // one line per completed operation, printed as the results are loaded
  always_ff @(posedge clk) begin
    if (rst_n && state_q == FIN)
      $display("MON_DIV: dividend = %0d, divisor = %0d, quotient = %0d, remainder = %0d, dbz = %0d",
               mon_dvd_q, dsr_q, quot_d, rem_d, dbz_d);
  end
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random self-checking bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  int errors = 0;
  int checks = 0;
  int lat, pulses, busy_bad;
  logic [15:0] cap_q;
  logic [7:0]  cap_r;
  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(16'd990, 8'd99);
    chk("lat_990", lat, 17);
    chk("busy_990", busy_bad, 0);
    chk("q_990", quotient, 10);
    chk("r_990", remainder, 0);
    chk("dbz_990", div_by_zero, 0);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("q_hold", quotient, 10);
    op(16'd1000, 8'd33);
    chk("q_1000", quotient, 30);
    chk("r_1000", remainder, 10);
    op(16'd65535, 8'd1);
    chk("q_65535", quotient, 65535);
    chk("r_65535", remainder, 0);
    op(16'd7, 8'd200);
    chk("q_7", quotient, 0);
    chk("r_7", remainder, 7);
    op(16'd5, 8'd0);
    chk("lat_dbz", lat, 1);
    chk("q_dbz", quotient, 16'hFFFF);
    chk("r_dbz", remainder, 5);
    chk("dbz_set", div_by_zero, 1);
    @(posedge clk); #1;
    chk("dbz_hold", div_by_zero, 1);
    op(16'd396, 8'd99);
    chk("q_396", quotient, 4);
    chk("r_396", remainder, 0);
    chk("dbz_clr", div_by_zero, 0);
    dividend = 16'd990;
    divisor  = 8'd99;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dividend = 16'd1000;
    divisor  = 8'd33;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        cap_q = quotient;
        cap_r = remainder;
      end
      @(posedge clk); #1;
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_q", cap_q, 10);
    chk("ign_r", cap_r, 0);
    dividend = 16'd990;
    divisor  = 8'd99;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q", quotient, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("arst_nodone", pulses, 0);
    op(16'd255, 8'd16);
    chk("q_255", quotient, 15);
    chk("r_255", remainder, 15);
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_q", quotient, 14);
    chk("b2b_r", remainder, 2);
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      op(a, b);
      chk("rnd_lat", lat, 17);
      chk("rnd_inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk("rnd_rlt", 32'(remainder < b), 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
